// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared definitions for the ALU operation sequencer: FSM
//               state encoding, default opcode width and the field offsets
//               of the {op, a, b} ALU input word (op at top, a middle,
//               b low).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int c_OPC_W_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // Bit offsets of each field inside the ALU word for a given operand width.
    function automatic int fld_op_lsb(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int fld_a_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int fld_b_lsb(input int data_w);
        // b sits at the bottom of the word regardless of width
        return (data_w > 0) ? 0 : 0;
    endfunction

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/sat_counter8.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter8
// Description : 8-bit up counter that sticks at 255 instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    output logic [7:0] o_count
);

    logic [7:0] r_count;

    // Count increment requests, holding at all-ones once reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_inc && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter8
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Sequences one command at a time through an external
//               combinational ALU: register operands (DRIVE), allow one
//               settle cycle, capture the result (CAPTURE) and hold it on a
//               valid/ready response port (HOLD). Counts overflowing
//               responses in a saturating 8-bit counter.
//               Optional macro ALU_SEQ_ACCUM_EN adds input cmd_chain, which
//               substitutes the low DATA_W bits of the last captured result
//               for the a operand.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OPC_W  = c_OPC_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef ALU_SEQ_ACCUM_EN
    input  logic                      cmd_chain,
`endif
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [OPC_W-1:0]          cmd_op,
    input  logic [DATA_W-1:0]         cmd_a,
    input  logic [DATA_W-1:0]         cmd_b,
    output logic [OPC_W+2*DATA_W-1:0] alu_inp,
    input  logic [OPC_W+2*DATA_W-1:0] alu_out,
    input  logic                      alu_o,
    input  logic                      alu_carry,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [OPC_W+2*DATA_W-1:0] rsp_data,
    output logic                      rsp_o,
    output logic                      rsp_carry,
    output logic [7:0]                ovf_count
);

    localparam int c_ALU_W  = OPC_W + 2 * DATA_W;
    localparam int c_OP_LSB = fld_op_lsb(DATA_W);
    localparam int c_A_LSB  = fld_a_lsb(DATA_W);
    localparam int c_B_LSB  = fld_b_lsb(DATA_W);

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_xfer;
    logic                 w_ovf_inc;
    logic [DATA_W-1:0]    w_a;
    logic [c_ALU_W-1:0]   w_cmd_word;
    logic [c_ALU_W-1:0]   r_alu_inp;
    logic [c_ALU_W-1:0]   r_rsp_data;
    logic                 r_rsp_o;
    logic                 r_rsp_carry;

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake outputs; HOLD never accepts a command even
    // on the cycle it is released.
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_next = ST_DRIVE;
                end
            end
            ST_DRIVE:   w_state_next = ST_CAPTURE;
            ST_CAPTURE: w_state_next = ST_HOLD;
            ST_HOLD: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default:    w_state_next = ST_IDLE;
        endcase
    end

    assign w_xfer    = cmd_valid && cmd_ready;
    assign w_ovf_inc = (r_state == ST_CAPTURE) && alu_o;

`ifdef ALU_SEQ_ACCUM_EN
    // The captured response register doubles as the chaining accumulator;
    // it resets to zero with everything else.
    assign w_a = cmd_chain ? r_rsp_data[c_B_LSB +: DATA_W] : cmd_a;
`else
    assign w_a = cmd_a;
`endif

    // Assemble the {op, a, b} word from the package field offsets.
    always_comb begin
        w_cmd_word                       = '0;
        w_cmd_word[c_OP_LSB +: OPC_W]    = cmd_op;
        w_cmd_word[c_A_LSB  +: DATA_W]   = w_a;
        w_cmd_word[c_B_LSB  +: DATA_W]   = cmd_b;
    end

    // Operand register loads only on transfer; result registers load only
    // in CAPTURE so the payload is stable throughout HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_inp   <= '0;
            r_rsp_data  <= '0;
            r_rsp_o     <= 1'b0;
            r_rsp_carry <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_alu_inp <= w_cmd_word;
            end
            if (r_state == ST_CAPTURE) begin
                r_rsp_data  <= alu_out;
                r_rsp_o     <= alu_o;
                r_rsp_carry <= alu_carry;
            end
        end
    end

    assign alu_inp   = r_alu_inp;
    assign rsp_data  = r_rsp_data;
    assign rsp_o     = r_rsp_o;
    assign rsp_carry = r_rsp_carry;

    sat_counter8 u_ovf_count (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_ovf_inc),
        .o_count (ovf_count)
    );

endmodule : alu_op_sequencer
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Self-checking bench for alu_op_sequencer with a behavioural
//               16-bit ALU (add, sub, and, or) attached to alu_inp/alu_out.
//               ALU word result layout: {op, a, result}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [33:0] alu_inp;
    logic [33:0] alu_out;
    logic        alu_o;
    logic        alu_carry;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [33:0] rsp_data;
    logic        rsp_o;
    logic        rsp_carry;
    logic [7:0]  ovf_count;
    logic        force_o;
`ifdef ALU_SEQ_ACCUM_EN
    logic        cmd_chain;
`endif

    int checks   = 0;
    int failures = 0;

    alu_op_sequencer #(.DATA_W(16), .OPC_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ALU_SEQ_ACCUM_EN
        .cmd_chain (cmd_chain),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_inp   (alu_inp),
        .alu_out   (alu_out),
        .alu_o     (alu_o),
        .alu_carry (alu_carry),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_o     (rsp_o),
        .rsp_carry (rsp_carry),
        .ovf_count (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {overflow, carry, {op, a, result}}.
    function automatic logic [35:0] alu_model(input logic [33:0] inp);
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        logic        o;
        op = inp[33:32];
        a  = inp[31:16];
        b  = inp[15:0];
        s  = 17'd0;
        r  = 16'd0;
        c  = 1'b0;
        o  = 1'b0;
        case (op)
            2'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                o = (a[15] == b[15]) && (r[15] != a[15]);
            end
            2'd1: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[15:0];
                c = s[16];
                o = (a[15] != b[15]) && (r[15] != a[15]);
            end
            2'd2: r = a & b;
            default: r = a | b;
        endcase
        return {o, c, op, a, r};
    endfunction

    logic [35:0] alu_res;
    assign alu_res   = alu_model(alu_inp);
    assign alu_out   = alu_res[33:0];
    assign alu_carry = alu_res[34];
    assign alu_o     = alu_res[35] | force_o;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        chain;
        logic [33:0] exp_inp;
        logic [33:0] exp_data;
        logic        exp_o;
        logic        exp_c;
    } vec_t;

    vec_t vecs[8];

    // One full command with rsp_ready high, checking every phase.
    // Starts expecting IDLE at the next negedge, ends sampling HOLD.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        check({tag, " cmd_ready idle"}, {63'd0, cmd_ready}, 64'd1);
        cmd_op    = v.op;
        cmd_a     = v.a;
        cmd_b     = v.b;
`ifdef ALU_SEQ_ACCUM_EN
        cmd_chain = v.chain;
`endif
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);                     // DRIVE
        cmd_valid = 1'b0;
        check({tag, " alu_inp"}, {30'd0, alu_inp}, {30'd0, v.exp_inp});
        check({tag, " rsp_valid drive"}, {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);                     // CAPTURE
        check({tag, " rsp_valid capture"}, {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);                     // HOLD
        check({tag, " rsp_valid hold"}, {63'd0, rsp_valid}, 64'd1);
        check({tag, " rsp_data"}, {30'd0, rsp_data}, {30'd0, v.exp_data});
        check({tag, " rsp_o/carry"}, {62'd0, rsp_o, rsp_carry}, {62'd0, v.exp_o, v.exp_c});
    endtask

    // Same handshake without checks, used for bulk traffic.
    task automatic run_quiet(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        logic [33:0] held_inp;

        //          op    a         b         ch    exp_inp         exp_data        o     c
        vecs[0] = '{2'd0, 16'h00FF, 16'h0000, 1'b0, 34'h000FF0000, 34'h000FF00FF, 1'b0, 1'b0};
        vecs[1] = '{2'd1, 16'h00FF, 16'h0000, 1'b0, 34'h100FF0000, 34'h100FF00FF, 1'b0, 1'b0};
        vecs[2] = '{2'd2, 16'h00FF, 16'h0000, 1'b0, 34'h200FF0000, 34'h200FF0000, 1'b0, 1'b0};
        vecs[3] = '{2'd3, 16'h00FF, 16'h0000, 1'b0, 34'h300FF0000, 34'h300FF00FF, 1'b0, 1'b0};
        vecs[4] = '{2'd0, 16'h7FFF, 16'h0001, 1'b0, 34'h07FFF0001, 34'h07FFF8000, 1'b1, 1'b0};
        vecs[5] = '{2'd0, 16'hFFFF, 16'h0001, 1'b0, 34'h0FFFF0001, 34'h0FFFF0000, 1'b0, 1'b1};
        vecs[6] = '{2'd1, 16'h8000, 16'h0001, 1'b0, 34'h180000001, 34'h180007FFF, 1'b1, 1'b0};
        vecs[7] = '{2'd1, 16'h0000, 16'h0001, 1'b0, 34'h100000001, 34'h10000FFFF, 1'b0, 1'b1};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_a     = 16'd0;
        cmd_b     = 16'd0;
        rsp_ready = 1'b0;
        force_o   = 1'b0;
`ifdef ALU_SEQ_ACCUM_EN
        cmd_chain = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("reset cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset alu_inp", {30'd0, alu_inp}, 64'd0);
        check("reset rsp_data", {30'd0, rsp_data}, 64'd0);
        check("reset ovf_count", {56'd0, ovf_count}, 64'd0);

        // Table-driven vectors: opcode sweep plus overflow/carry boundaries
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        check("ovf_count after table", {56'd0, ovf_count}, 64'd2);

        // Backpressure: HOLD for 5 cycles with a competing command
        v = '{2'd3, 16'h1234, 16'h00F0, 1'b0, 34'h3123400F0, 34'h3123412F4, 1'b0, 1'b0};
        @(negedge clk);
        cmd_op    = v.op;
        cmd_a     = v.a;
        cmd_b     = v.b;
        cmd_valid = 1'b1;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        held_inp  = v.exp_inp;
        check("bp alu_inp", {30'd0, alu_inp}, {30'd0, held_inp});
        @(negedge clk);
        @(negedge clk);
        cmd_op    = 2'd0;
        cmd_a     = 16'hFFFF;
        cmd_b     = 16'hFFFF;
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d rsp_valid", k), {63'd0, rsp_valid}, 64'd1);
            check($sformatf("bp%0d rsp_data", k), {30'd0, rsp_data}, {30'd0, v.exp_data});
            check($sformatf("bp%0d cmd_ready", k), {63'd0, cmd_ready}, 64'd0);
            check($sformatf("bp%0d alu_inp", k), {30'd0, alu_inp}, {30'd0, held_inp});
            @(negedge clk);
        end
        // Release with cmd_valid still high: must return to IDLE without accepting
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp release rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("bp release cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("bp release alu_inp", {30'd0, alu_inp}, {30'd0, held_inp});
        cmd_valid = 1'b0;
        check("bp ovf_count", {56'd0, ovf_count}, 64'd2);

        // Asynchronous reset in DRIVE
        @(negedge clk);
        cmd_op    = 2'd0;
        cmd_a     = 16'h0001;
        cmd_b     = 16'h0002;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst pre alu_inp", {30'd0, alu_inp}, 64'h000010002);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst async rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst async alu_inp", {30'd0, alu_inp}, 64'd0);
        check("rst async rsp_data", {30'd0, rsp_data}, 64'd0);
        check("rst async ovf_count", {56'd0, ovf_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst release cmd_ready", {63'd0, cmd_ready}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst no rsp %0d", k), {63'd0, rsp_valid}, 64'd0);
        end

        // Saturation of the overflow counter
        force_o = 1'b1;
        for (int i = 0; i < 260; i++) begin
            run_quiet(2'd2, 16'h0000, 16'h0000);
            if (i == 253) begin
                check("ovf_count 254", {56'd0, ovf_count}, 64'd254);
            end
        end
        check("ovf_count saturated", {56'd0, ovf_count}, 64'd255);
        force_o = 1'b0;

`ifdef ALU_SEQ_ACCUM_EN
        // Chained accumulate: second a operand comes from first result
        v = '{2'd0, 16'h0003, 16'h0004, 1'b0, 34'h000030004, 34'h000030007, 1'b0, 1'b0};
        run_vec(v, "chain0");
        v = '{2'd0, 16'hAAAA, 16'h0001, 1'b1, 34'h000070001, 34'h000070008, 1'b0, 1'b0};
        run_vec(v, "chain1");
        cmd_chain = 1'b0;
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_op_sequencer
`default_nettype wire
